// File: rtl/battle_turn_scheduler.sv
// Sequences one battle turn: collects both moves, orders attacks by speed,
// drives the shared damage calculator, applies damage to owned HP registers.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin battle (ignored while busy)
//   p_hp_init/ai_hp_init: starting HP, sampled on accepted start
//   p_speed/ai_speed    : speed stats, sampled in ORDER
//   p_move_*/ai_move_*  : valid/ready move entry per trainer
//   calc_*              : req/done handshake to the damage calculator
//   p_hp/ai_hp          : current HP
//   turn_count          : completed turns, saturating at 255
//   busy/victory/loss   : status and held battle result
module battle_turn_scheduler #(
   parameter int HP_W  = 8,
   parameter int SPD_W = 8,
   parameter int DMG_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [HP_W-1:0]  p_hp_init,
   input  logic [HP_W-1:0]  ai_hp_init,
   input  logic [SPD_W-1:0] p_speed,
   input  logic [SPD_W-1:0] ai_speed,
   input  logic             p_move_valid,
   input  logic [1:0]       p_move,
   output logic             p_move_ready,
   input  logic             ai_move_valid,
   input  logic [1:0]       ai_move,
   output logic             ai_move_ready,
   output logic             calc_req,
   output logic             calc_attacker,
   output logic [1:0]       calc_move,
   input  logic             calc_done,
   input  logic [DMG_W-1:0] calc_damage,
   output logic [HP_W-1:0]  p_hp,
   output logic [HP_W-1:0]  ai_hp,
   output logic [7:0]       turn_count,
   output logic             busy,
   output logic             victory,
   output logic             loss
);

   localparam int CW = HP_W + DMG_W;

   typedef enum logic [3:0] {
      S_IDLE,
      S_COLLECT,
      S_ORDER,
      S_CALC1,
      S_APPLY1,
      S_CALC2,
      S_APPLY2,
      S_VICTORY,
      S_LOSS
   } state_t;

   state_t           state;
   logic             p_have;
   logic             ai_have;
   logic [1:0]       p_mv;
   logic [1:0]       ai_mv;
   logic             tie_flag;
   logic [DMG_W-1:0] dmg;

   logic             p_xfer;
   logic             ai_xfer;
   logic             ai_first;
   logic [HP_W-1:0]  def_hp;
   logic [HP_W-1:0]  new_hp;
   logic [7:0]       tc_inc;

   // Saturating subtract done in a wider domain so HP and damage widths
   // may differ without wrap-around.
   function automatic logic [HP_W-1:0] sat_sub(
      input logic [HP_W-1:0]  h,
      input logic [DMG_W-1:0] d
   );
      logic [CW-1:0] hx;
      logic [CW-1:0] dx;
      logic [CW-1:0] r;
      hx = CW'(h);
      dx = CW'(d);
      r  = hx - dx;
      sat_sub = (hx > dx) ? r[HP_W-1:0] : '0;
   endfunction

   always_comb begin
      p_xfer  = p_move_valid & p_move_ready;
      ai_xfer = ai_move_valid & ai_move_ready;
      if (p_speed > ai_speed)
         ai_first = 1'b0;
      else if (ai_speed > p_speed)
         ai_first = 1'b1;
      else
         ai_first = tie_flag;
      // calc_attacker still names the current attacker during APPLY
      def_hp = calc_attacker ? p_hp : ai_hp;
      new_hp = sat_sub(def_hp, dmg);
      tc_inc = (turn_count != 8'hFF) ? turn_count + 8'd1 : turn_count;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         p_have        <= 1'b0;
         ai_have       <= 1'b0;
         p_mv          <= 2'd0;
         ai_mv         <= 2'd0;
         tie_flag      <= 1'b0;
         dmg           <= '0;
         p_move_ready  <= 1'b0;
         ai_move_ready <= 1'b0;
         calc_req      <= 1'b0;
         calc_attacker <= 1'b0;
         calc_move     <= 2'd0;
         p_hp          <= '0;
         ai_hp         <= '0;
         turn_count    <= 8'd0;
         busy          <= 1'b0;
         victory       <= 1'b0;
         loss          <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_VICTORY, S_LOSS: begin
               if (start) begin
                  state         <= S_COLLECT;
                  p_hp          <= p_hp_init;
                  ai_hp         <= ai_hp_init;
                  turn_count    <= 8'd0;
                  tie_flag      <= 1'b0;
                  p_have        <= 1'b0;
                  ai_have       <= 1'b0;
                  p_move_ready  <= 1'b1;
                  ai_move_ready <= 1'b1;
                  busy          <= 1'b1;
                  victory       <= 1'b0;
                  loss          <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (p_xfer) begin
                  p_mv         <= p_move;
                  p_have       <= 1'b1;
                  p_move_ready <= 1'b0;
               end
               if (ai_xfer) begin
                  ai_mv         <= ai_move;
                  ai_have       <= 1'b1;
                  ai_move_ready <= 1'b0;
               end
               if ((p_have | p_xfer) & (ai_have | ai_xfer))
                  state <= S_ORDER;
            end
            S_ORDER: begin
               state         <= S_CALC1;
               calc_req      <= 1'b1;
               calc_attacker <= ai_first;
               calc_move     <= ai_first ? ai_mv : p_mv;
               if (p_speed == ai_speed)
                  tie_flag <= ~tie_flag;
            end
            S_CALC1, S_CALC2: begin
               if (calc_done) begin
                  dmg      <= calc_damage;
                  calc_req <= 1'b0;
                  state    <= (state == S_CALC1) ? S_APPLY1 : S_APPLY2;
               end
            end
            S_APPLY1, S_APPLY2: begin
               if (calc_attacker)
                  p_hp <= new_hp;
               else
                  ai_hp <= new_hp;
               if (new_hp == '0) begin
                  // first faint ends the battle; any second attack is skipped
                  state         <= calc_attacker ? S_LOSS : S_VICTORY;
                  victory       <= ~calc_attacker;
                  loss          <= calc_attacker;
                  busy          <= 1'b0;
                  turn_count    <= tc_inc;
                  calc_attacker <= 1'b0;
                  calc_move     <= 2'd0;
               end else if (state == S_APPLY1) begin
                  state         <= S_CALC2;
                  calc_req      <= 1'b1;
                  calc_attacker <= ~calc_attacker;
                  calc_move     <= calc_attacker ? p_mv : ai_mv;
               end else begin
                  state         <= S_COLLECT;
                  turn_count    <= tc_inc;
                  p_have        <= 1'b0;
                  ai_have       <= 1'b0;
                  p_move_ready  <= 1'b1;
                  ai_move_ready <= 1'b1;
                  calc_attacker <= 1'b0;
                  calc_move     <= 2'd0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
